// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and helpers for the elastic register pipeline
package pipe_pkg;
  localparam int DEPTH_MIN = 1;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one elastic register stage; data only moves with a valid item
module pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  logic             in_v,
  input  logic [WIDTH-1:0] in_d,
  output logic             v,
  output logic [WIDTH-1:0] d
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= 1'b0;
      d <= '0;
    end else begin
      v <= flush ? 1'b0 : load ? in_v : v;
      if (!flush && load && in_v) d <= in_d;
    end
endmodule

// File: rtl/pipe_n_vr.sv
// pipe_n_vr: N-stage valid/ready elastic pipeline; PIPE_OCCUPANCY_EN adds the occupancy count port
module pipe_n_vr
  import pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef PIPE_OCCUPANCY_EN
  ,
  output logic [cnt_w(DEPTH)-1:0] occupancy
`endif
);
  logic [DEPTH:0]            cv;
  logic [DEPTH:0][WIDTH-1:0] cd;
  logic [DEPTH-1:0]          r;
  if (DEPTH < DEPTH_MIN) begin : g_bad_depth
    $error("pipe_n_vr: DEPTH must be at least %0d", DEPTH_MIN);
  end
  assign cv[0] = in_valid;
  assign cd[0] = in_data;
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    // A stage can take an item if any stage from here to the output is free, or the output drains.
    assign r[g] = ~&cv[DEPTH:g+1] | out_ready;
    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk  (clk),
      .rst_n(rst_n),
      .flush(flush),
      .load (r[g]),
      .in_v (cv[g]),
      .in_d (cd[g]),
      .v    (cv[g+1]),
      .d    (cd[g+1])
    );
  end
  assign in_ready  = r[0] && !flush;
  assign out_valid = cv[DEPTH];
  assign out_data  = cd[DEPTH];
`ifdef PIPE_OCCUPANCY_EN
  localparam int CW = cnt_w(DEPTH);
  logic in_xfer, out_xfer;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) occupancy <= '0;
    else occupancy <= flush ? '0 : occupancy + CW'(in_xfer) - CW'(out_xfer);
`endif
endmodule

// File: tb/tb_pipe_n_vr.sv
// tb_pipe_n_vr: directed checks of pipe_n_vr at DEPTH=4/WIDTH=8 and DEPTH=1/WIDTH=16
module tb_pipe_n_vr;
  logic clk, rst_n;
  logic flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0] b_in_data, b_out_data;
`ifdef PIPE_OCCUPANCY_EN
  logic [2:0] occ;
  logic [0:0] b_occ;
`endif
  int n_cmp = 0;
  int n_err = 0;

  pipe_n_vr #(.WIDTH(8), .DEPTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
`ifdef PIPE_OCCUPANCY_EN
    , .occupancy(occ)
`endif
  );

  pipe_n_vr #(.WIDTH(16), .DEPTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready)
`ifdef PIPE_OCCUPANCY_EN
    , .occupancy(b_occ)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_occ(input string tag, input logic [31:0] exp);
`ifdef PIPE_OCCUPANCY_EN
    chk(tag, 32'(occ), exp);
`endif
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] items [4];

  initial begin
    items = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk_occ("rst_occ", 0);
    rst_n = 1'b1;
    // stream four items through a free pipe
    out_ready = 1'b1;
    for (int e = 0; e < 8; e++) begin
      in_valid = (e < 4);
      if (e < 4) in_data = items[e];
      tick;
      chk($sformatf("s1_valid_e%0d", e), 32'(out_valid), (e >= 3 && e <= 6) ? 1 : 0);
      if (e >= 3 && e <= 6) chk($sformatf("s1_data_e%0d", e), 32'(out_data), 32'(items[e-3]));
      chk_occ($sformatf("s1_occ_e%0d", e), e <= 3 ? e + 1 : 7 - e);
    end
    // fill under backpressure, then pass-through when full
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = 8'(i + 1);
      #1;
      chk($sformatf("s2_fill_ready%0d", i), 32'(in_ready), 1);
      tick;
    end
    in_data = 8'h05;
    #1;
    chk("s2_full_in_ready", 32'(in_ready), 0);
    chk("s2_full_out_valid", 32'(out_valid), 1);
    chk("s2_full_out_data", 32'(out_data), 8'h01);
    chk_occ("s2_full_occ", 4);
    tick;
    chk("s2_hold_out_data", 32'(out_data), 8'h01);
    chk("s2_hold_in_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    #1;
    chk("s2_pass_in_ready", 32'(in_ready), 1);
    tick;
    chk("s2_pass_out_data", 32'(out_data), 8'h02);
    chk_occ("s2_pass_occ", 4);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("s2_drain_valid%0d", i), 32'(out_valid), i < 3 ? 1 : 0);
      if (i < 3) chk($sformatf("s2_drain_data%0d", i), 32'(out_data), 32'(i + 3));
    end
    // bubble collapse behind a stalled item
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hA5;
    tick;
    in_valid = 1'b0;
    tick;
    in_valid = 1'b1; in_data = 8'hB6;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    chk("s3_stall_data", 32'(out_data), 8'hA5);
    chk_occ("s3_occ", 2);
    out_ready = 1'b1;
    tick;
    chk("s3_next_valid", 32'(out_valid), 1);
    chk("s3_next_data", 32'(out_data), 8'hB6);
    tick;
    chk("s3_empty_valid", 32'(out_valid), 0);
    // flush with three items held and an offered item
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h61 + i);
      tick;
    end
    in_valid = 1'b0;
    tick;
    in_valid = 1'b1; in_data = 8'hC7; flush = 1'b1;
    #1;
    chk("s4_flush_in_ready", 32'(in_ready), 0);
    chk("s4_flush_out_valid", 32'(out_valid), 1);
    chk_occ("s4_pre_occ", 3);
    tick;
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("s4_post_valid", 32'(out_valid), 0);
    chk("s4_post_data_kept", 32'(out_data), 8'h61);
    chk("s4_post_in_ready", 32'(in_ready), 1);
    chk_occ("s4_post_occ", 0);
    out_ready = 1'b1;
    repeat (4) tick;
    chk("s4_c7_dropped", 32'(out_valid), 0);
    // asynchronous reset mid-stream
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h71;
    tick;
    in_data = 8'h72;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    chk("s5_pre_valid", 32'(out_valid), 1);
    chk("s5_pre_data", 32'(out_data), 8'h71);
    chk_occ("s5_pre_occ", 2);
    #3 rst_n = 1'b0;
    #1;
    chk("s5_rst_valid", 32'(out_valid), 0);
    chk("s5_rst_data", 32'(out_data), 0);
    chk_occ("s5_rst_occ", 0);
    #2 rst_n = 1'b1;
    #1;
    chk("s5_rel_in_ready", 32'(in_ready), 1);
    in_valid = 1'b1; in_data = 8'hD8; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int e = 0; e < 4; e++) begin
      chk($sformatf("s5_d8_valid%0d", e), 32'(out_valid), e == 3 ? 1 : 0);
      if (e == 3) chk("s5_d8_data", 32'(out_data), 8'hD8);
      if (e < 3) tick;
    end
    // single-stage pipe with toggling out_ready
    b_in_valid = 1'b1; b_in_data = 16'h1234; b_out_ready = 1'b0;
    #1;
    chk("s6_rdy0", 32'(b_in_ready), 1);
    tick;
    chk("s6_out0", 32'(b_out_data), 16'h1234);
    chk("s6_val0", 32'(b_out_valid), 1);
    b_in_data = 16'h5678; b_out_ready = 1'b1;
    #1;
    chk("s6_rdy1", 32'(b_in_ready), 1);
    tick;
    chk("s6_out1", 32'(b_out_data), 16'h5678);
    chk("s6_val1", 32'(b_out_valid), 1);
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    #1;
    chk("s6_rdy2", 32'(b_in_ready), 0);
    tick;
    chk("s6_out2", 32'(b_out_data), 16'h5678);
    chk("s6_val2", 32'(b_out_valid), 1);
    b_out_ready = 1'b1;
    #1;
    chk("s6_rdy3", 32'(b_in_ready), 1);
    tick;
    chk("s6_val3", 32'(b_out_valid), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
